// File: rtl/dmx8_pkg.sv
// Shared types and sizing for the 1-to-8, 4-bit registered write distributor.
package dmx8_pkg;
  localparam int NUM_ENTRIES = 8;
  localparam int DATA_W      = 4;
  localparam int SEL_W       = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; produces per-entry write strobes.
module dec3to8
  import dmx8_pkg::*;
(
  input  logic [SEL_W-1:0]       sel,
  input  logic                   en,
  output logic [NUM_ENTRIES-1:0] onehot
);
  always_comb begin
    onehot      = '0;
    onehot[sel] = en;
  end
endmodule

// File: rtl/dmx8_4bits_bank.sv
// Registered 1-to-8 write distributor with sequential fill (broadcast) mode.
// Optional DMX8_WRCNT_EN adds a saturating entry-write counter output wr_cnt.
module dmx8_4bits_bank
  import dmx8_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_VAL = 4'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   fill,
  input  logic [DATA_W-1:0]      d,
  input  logic                   s2,
  input  logic                   s1,
  input  logic                   s0,
  output logic [DATA_W-1:0]      a,
  output logic [DATA_W-1:0]      b,
  output logic [DATA_W-1:0]      c,
  output logic [DATA_W-1:0]      d_o,
  output logic [DATA_W-1:0]      e,
  output logic [DATA_W-1:0]      f,
  output logic [DATA_W-1:0]      g,
  output logic [DATA_W-1:0]      h,
  output logic [NUM_ENTRIES-1:0] vld,
`ifdef DMX8_WRCNT_EN
  output logic [7:0]             wr_cnt,
`endif
  output logic                   busy,
  output logic                   done
);
  state_t                  state, state_nxt;
  logic [SEL_W-1:0]        cnt;
  logic [DATA_W-1:0]       fill_data;
  logic [DATA_W-1:0]       ent [NUM_ENTRIES];
  logic                    accept, wr_single, fill_step;
  logic [SEL_W-1:0]        wr_sel;
  logic [DATA_W-1:0]       wr_data;
  logic [NUM_ENTRIES-1:0]  we;

  // Acceptance decodes state directly so in_ready never feeds back into itself.
  assign accept    = in_valid && (state == IDLE);
  assign wr_single = accept && !fill;
  assign fill_step = (state == FILL);
  assign wr_sel    = fill_step ? cnt : {s2, s1, s0};
  assign wr_data   = fill_step ? fill_data : d;

  dec3to8 u_dec (
    .sel    (wr_sel),
    .en     (wr_single || fill_step),
    .onehot (we)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept && fill) state_nxt = FILL;
      end
      FILL: begin
        busy = 1'b1;
        if (cnt == 3'd7) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      fill_data <= '0;
      vld       <= '0;
      for (int k = 0; k < NUM_ENTRIES; k++) ent[k] <= RESET_VAL;
    end else begin
      if (accept && fill) begin
        fill_data <= d;
        cnt       <= '0;
      end else if (fill_step) begin
        cnt <= cnt + 3'd1;
      end
      for (int k = 0; k < NUM_ENTRIES; k++)
        if (we[k]) ent[k] <= wr_data;
      vld <= vld | we;
    end
  end

`ifdef DMX8_WRCNT_EN
  always_ff @(posedge clk) begin
    if (reset)                        wr_cnt <= '0;
    else if ((|we) && wr_cnt != 8'hFF) wr_cnt <= wr_cnt + 8'd1;
  end
`endif

  assign a   = ent[0];
  assign b   = ent[1];
  assign c   = ent[2];
  assign d_o = ent[3];
  assign e   = ent[4];
  assign f   = ent[5];
  assign g   = ent[6];
  assign h   = ent[7];
endmodule
